// File: rtl/read_superpixel_pkg.sv
// ---------------------------------------------------------------------------
// read_superpixel_pkg
// Shared VGA/superpixel constants, the scan FSM state type and the shift-add
// helpers used to turn a logical superpixel coordinate into a frame-buffer
// address. The draw blocks use the same definitions.
// Ports: none (package).
// ---------------------------------------------------------------------------
package read_superpixel_pkg;

   localparam int SPIXEL_X_WIDTH = 5;
   localparam int SPIXEL_Y_WIDTH = 5;
   localparam logic [SPIXEL_Y_WIDTH-1:0] SPIXEL_Y_MAX = 5'd23;
   localparam int SPIXEL_SIZE    = 20;
   localparam int PIXEL_X_MAX    = 639;
   localparam int PIXEL_Y_MAX    = 479;
   localparam int LINE_STRIDE    = PIXEL_X_MAX + 1;
   localparam int ADDR_WIDTH     = 19;
   localparam int COLOR_ID_WIDTH = 8;
   localparam int RD_LATENCY     = 2;

   localparam int CNT_WIDTH = $clog2(SPIXEL_SIZE);
   localparam logic [CNT_WIDTH-1:0]  CNT_LAST = CNT_WIDTH'(SPIXEL_SIZE - 1);
   localparam logic [ADDR_WIDTH-1:0] STRIDE   = ADDR_WIDTH'(LINE_STRIDE);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      DONE
   } spixel_state_t;

   // Multiply by a constant as a sum of shifted copies; only the set bits of
   // the constant produce adders, so no multiplier is inferred.
   function automatic logic [ADDR_WIDTH-1:0] mul_const(input logic [ADDR_WIDTH-1:0] v,
                                                       input int k);
      logic [ADDR_WIDTH-1:0] acc;
      acc = '0;
      for (int i = 0; i < ADDR_WIDTH; i++) begin
         if (k[i]) begin
            acc = acc + (v << i);
         end
      end
      return acc;
   endfunction

   // Address of the top-left physical pixel of superpixel (x, y).
   function automatic logic [ADDR_WIDTH-1:0] spixel_base(input logic [SPIXEL_X_WIDTH-1:0] x,
                                                         input logic [SPIXEL_Y_WIDTH-1:0] y);
      return mul_const(ADDR_WIDTH'(y), SPIXEL_SIZE * LINE_STRIDE)
           + mul_const(ADDR_WIDTH'(x), SPIXEL_SIZE);
   endfunction

endpackage

// File: rtl/read_superpixel_if.sv
// ---------------------------------------------------------------------------
// read_superpixel_if
// Request/response handshake of the superpixel reader plus its frame-buffer
// read port.
//   x, y, ireq                    : query coordinate and request strobe
//   obusy, odone                  : scan in progress / one-cycle completion
//   odata, ouniform, oerr         : query result
//   oaddr, ordren, irdata         : frame-buffer read port
// Modport slave is the reader itself; master is the requester/memory side.
// ---------------------------------------------------------------------------
interface read_superpixel_if;
   import read_superpixel_pkg::*;

   logic [SPIXEL_X_WIDTH-1:0] x;
   logic [SPIXEL_Y_WIDTH-1:0] y;
   logic                      ireq;
   logic                      obusy;
   logic                      odone;
   logic [COLOR_ID_WIDTH-1:0] odata;
   logic                      ouniform;
   logic                      oerr;
   logic [ADDR_WIDTH-1:0]     oaddr;
   logic                      ordren;
   logic [COLOR_ID_WIDTH-1:0] irdata;

   modport slave (
      input  x, y, ireq, irdata,
      output obusy, odone, odata, ouniform, oerr, oaddr, ordren
   );

   modport master (
      output x, y, ireq, irdata,
      input  obusy, odone, odata, ouniform, oerr, oaddr, ordren
   );
endinterface

// File: rtl/read_superpixel_spixel_addr_gen.sv
// ---------------------------------------------------------------------------
// spixel_addr_gen
// Raster address generator for one superpixel. load latches the base address
// of (x, y); while step is high one address per cycle is produced, walking
// SPIXEL_SIZE pixels per row and SPIXEL_SIZE rows. last flags the final
// address of the burst; the address is held after it.
// With READ_SPIXEL_FAST_EN defined only the base address is produced and no
// px/py counters exist.
// Ports: clk, rst_n (sync active-low), load, x, y, step -> addr, rden, last.
// ---------------------------------------------------------------------------
module spixel_addr_gen
   import read_superpixel_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      load,
   input  logic [SPIXEL_X_WIDTH-1:0] x,
   input  logic [SPIXEL_Y_WIDTH-1:0] y,
   input  logic                      step,
   output logic [ADDR_WIDTH-1:0]     addr,
   output logic                      rden,
   output logic                      last
);

   logic [ADDR_WIDTH-1:0] addr_q;

`ifdef READ_SPIXEL_FAST_EN
   // Single read: the base address is the only address.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr_q <= '0;
      end else if (load) begin
         addr_q <= spixel_base(x, y);
      end
   end

   assign last = step;
`else
   logic [ADDR_WIDTH-1:0] row_ptr;
   logic [CNT_WIDTH-1:0]  px;
   logic [CNT_WIDTH-1:0]  py;

   // row_ptr remembers the start of the current row so a row wrap is one
   // stride add rather than a recomputation from px/py.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr_q  <= '0;
         row_ptr <= '0;
         px      <= '0;
         py      <= '0;
      end else if (load) begin
         addr_q  <= spixel_base(x, y);
         row_ptr <= spixel_base(x, y);
         px      <= '0;
         py      <= '0;
      end else if (step && !last) begin
         if (px == CNT_LAST) begin
            px      <= '0;
            py      <= py + 1'b1;
            row_ptr <= row_ptr + STRIDE;
            addr_q  <= row_ptr + STRIDE;
         end else begin
            px      <= px + 1'b1;
            addr_q  <= addr_q + 1'b1;
         end
      end
   end

   assign last = (px == CNT_LAST) && (py == CNT_LAST);
`endif

   assign addr = addr_q;
   assign rden = step;

endmodule

// File: rtl/read_superpixel.sv
// ---------------------------------------------------------------------------
// read_superpixel
// Reads every physical pixel of a logical superpixel from the frame buffer
// and reports the top-left colour and whether all pixels share it.
// Ports: clk, rst_n (sync active-low), bus (read_superpixel_if.slave).
// Optional READ_SPIXEL_FAST_EN: read only the top-left pixel and report the
// superpixel as uniform.
// ---------------------------------------------------------------------------
module read_superpixel
   import read_superpixel_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   read_superpixel_if.slave  bus
);

   // Marks the oldest in-flight read, whose data is on irdata this cycle.
   localparam logic [RD_LATENCY-1:0] VLD_TOP = RD_LATENCY'(1) << (RD_LATENCY - 1);

   spixel_state_t state, state_nxt;

   logic                      accept;
   logic                      range_err;
   logic                      rden;
   logic                      last;
   logic [ADDR_WIDTH-1:0]     addr;
   logic [RD_LATENCY-1:0]     vld_sr;
   logic                      rd_valid;
   logic                      drain_empty;
   logic                      got_first;
   logic [COLOR_ID_WIDTH-1:0] odata_q;
   logic                      uniform_q;
   logic                      err_q;

   assign accept      = (state == IDLE) && bus.ireq;
   assign range_err   = (bus.y > SPIXEL_Y_MAX);
   assign rd_valid    = vld_sr[RD_LATENCY-1];
   // Only the final stage may still be occupied: its data is consumed this
   // cycle, so odone next cycle already sees the complete result.
   assign drain_empty = ((vld_sr & ~VLD_TOP) == '0);

   spixel_addr_gen u_addr_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (accept),
      .x     (bus.x),
      .y     (bus.y),
      .step  (state == ISSUE),
      .addr  (addr),
      .rden  (rden),
      .last  (last)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; out-of-range requests skip straight to DONE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (bus.ireq) begin
               state_nxt = range_err ? DONE : ISSUE;
            end
         end
         ISSUE: begin
            if (last) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (drain_empty) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Tracks which cycles carry returned read data; cleared by reset so
   // reads in flight at reset are ignored.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_sr <= '0;
      end else begin
         vld_sr <= (vld_sr << 1) | RD_LATENCY'(rden);
      end
   end

   // Result registers: cleared at acceptance, first return sets the colour.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         odata_q   <= '0;
         uniform_q <= 1'b0;
         err_q     <= 1'b0;
         got_first <= 1'b0;
      end else if (accept) begin
         odata_q   <= '0;
         uniform_q <= 1'b0;
         err_q     <= range_err;
         got_first <= 1'b0;
      end else if (rd_valid) begin
         got_first <= 1'b1;
         if (!got_first) begin
            odata_q <= bus.irdata;
         end
`ifdef READ_SPIXEL_FAST_EN
         uniform_q <= 1'b1;
`else
         if (!got_first) begin
            uniform_q <= 1'b1;
         end else if (bus.irdata != odata_q) begin
            uniform_q <= 1'b0;
         end
`endif
      end
   end

   assign bus.obusy    = (state == ISSUE) || (state == DRAIN);
   assign bus.odone    = (state == DONE);
   assign bus.odata    = odata_q;
   assign bus.ouniform = uniform_q;
   assign bus.oerr     = err_q;
   assign bus.oaddr    = addr;
   assign bus.ordren   = rden;

endmodule

// File: tb/tb_read_superpixel.sv
// ---------------------------------------------------------------------------
// tb_read_superpixel
// Self-checking bench for read_superpixel. A frame-buffer model with the
// configured read latency answers the DUT's reads; expected addresses,
// latencies and results are derived from the superpixel geometry.
// Honours READ_SPIXEL_FAST_EN when the design is built with it.
// ---------------------------------------------------------------------------
module tb_read_superpixel;
   import read_superpixel_pkg::*;

   localparam int FB_SIZE = (PIXEL_X_MAX + 1) * (PIXEL_Y_MAX + 1);

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   int checks = 0;
   int passes = 0;

   logic [7:0] fb [FB_SIZE];
   logic [7:0] pipe [RD_LATENCY];

   int         rx, ry;
   logic [7:0] col;

   read_superpixel_if bus ();

   read_superpixel dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #10 clk = ~clk;

   // Frame-buffer read port; junk data when no read was issued.
   always @(posedge clk) begin
      if (bus.ordren && int'(bus.oaddr) < FB_SIZE) begin
         pipe[0] <= fb[bus.oaddr];
      end else begin
         pipe[0] <= 8'($urandom);
      end
      for (int i = 1; i < RD_LATENCY; i++) begin
         pipe[i] <= pipe[i-1];
      end
   end

   assign bus.irdata = pipe[RD_LATENCY-1];

   function automatic int pix_addr(input int sx, input int sy, input int c, input int r);
      return (sy * SPIXEL_SIZE + r) * (PIXEL_X_MAX + 1) + sx * SPIXEL_SIZE + c;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic fill(input int sx, input int sy, input logic [7:0] c);
      for (int r = 0; r < SPIXEL_SIZE; r++) begin
         for (int cc = 0; cc < SPIXEL_SIZE; cc++) begin
            fb[pix_addr(sx, sy, cc, r)] = c;
         end
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, " obusy"},    32'(bus.obusy),    0);
      check({tag, " odone"},    32'(bus.odone),    0);
      check({tag, " odata"},    32'(bus.odata),    0);
      check({tag, " ouniform"}, 32'(bus.ouniform), 0);
      check({tag, " oerr"},     32'(bus.oerr),     0);
      check({tag, " oaddr"},    32'(bus.oaddr),    0);
      check({tag, " ordren"},   32'(bus.ordren),   0);
   endtask

   task automatic run_request(input int qx, input int qy, input int ghost_at,
                              input int abort_at, input string tag);
      int         exp_addrs[$];
      int         got_addrs[$];
      int         exp_lat, n, done_cyc, bad;
      logic [7:0] exp_data, got_data;
      logic       exp_uni, exp_err, got_uni, got_err, done_seen, busy1, stray;

      got_data = '0;
      got_uni  = 1'b0;
      got_err  = 1'b0;
      if (qy > int'(SPIXEL_Y_MAX)) begin
         exp_lat  = 1;
         exp_data = 8'h00;
         exp_uni  = 1'b0;
         exp_err  = 1'b1;
      end else begin
         exp_err  = 1'b0;
         exp_data = fb[pix_addr(qx, qy, 0, 0)];
         exp_uni  = 1'b1;
`ifdef READ_SPIXEL_FAST_EN
         exp_lat = 2 + RD_LATENCY;
         exp_addrs.push_back(pix_addr(qx, qy, 0, 0));
`else
         exp_lat = SPIXEL_SIZE * SPIXEL_SIZE + 1 + RD_LATENCY;
         for (int r = 0; r < SPIXEL_SIZE; r++) begin
            for (int c = 0; c < SPIXEL_SIZE; c++) begin
               exp_addrs.push_back(pix_addr(qx, qy, c, r));
               if (fb[pix_addr(qx, qy, c, r)] != exp_data) exp_uni = 1'b0;
            end
         end
`endif
      end

      @(negedge clk);
      bus.x    = 5'(qx);
      bus.y    = 5'(qy);
      bus.ireq = 1'b1;
      @(posedge clk);
      #1;
      bus.ireq = 1'b0;
      bus.x    = 5'($urandom);
      bus.y    = 5'($urandom);

      n = 0;
      done_seen = 1'b0;
      done_cyc  = -1;
      busy1     = 1'b0;
      while (!done_seen && n < 2000) begin
         @(negedge clk);
         n++;
         if (n == 1) busy1 = bus.obusy;
         if (bus.ordren) got_addrs.push_back(int'(bus.oaddr));
         if (bus.odone) begin
            done_seen = 1'b1;
            done_cyc  = n;
            got_data  = bus.odata;
            got_uni   = bus.ouniform;
            got_err   = bus.oerr;
         end
         bus.ireq = (n == ghost_at);
         if (n == ghost_at) begin
            bus.x = 5'($urandom);
            bus.y = 5'($urandom_range(0, 23));
         end
         if (n == abort_at) break;
      end

      bad = 0;
      for (int i = 0; i < got_addrs.size() && i < exp_addrs.size(); i++) begin
         if (got_addrs[i] != exp_addrs[i]) bad++;
      end

      if (abort_at > 0) begin
         check({tag, " no odone before reset"}, 32'(done_seen), 0);
         check({tag, " reads before reset"}, 32'(got_addrs.size()), 32'(abort_at));
         check({tag, " addr prefix"}, 32'(bad), 0);
         rst_n = 1'b0;
         @(posedge clk);
         #1;
         check_outputs_zero({tag, " after reset"});
         rst_n = 1'b1;
         stray = 1'b0;
         repeat (8) begin
            @(negedge clk);
            if (bus.odone || bus.ordren || bus.obusy) stray = 1'b1;
         end
         check({tag, " quiet after reset"}, 32'(stray), 0);
         return;
      end

      check({tag, " odone seen"}, 32'(done_seen), 1);
      check({tag, " latency"}, 32'(done_cyc), 32'(exp_lat));
      check({tag, " obusy cycle1"}, 32'(busy1), 32'(!exp_err));
      check({tag, " read count"}, 32'(got_addrs.size()), 32'(exp_addrs.size()));
      check({tag, " addr mismatches"}, 32'(bad), 0);
      check({tag, " odata"}, 32'(got_data), 32'(exp_data));
      check({tag, " ouniform"}, 32'(got_uni), 32'(exp_uni));
      check({tag, " oerr"}, 32'(got_err), 32'(exp_err));
      @(negedge clk);
      check({tag, " odone single pulse"}, 32'(bus.odone), 0);
   endtask

   initial begin
      bus.ireq = 1'b0;
      bus.x    = '0;
      bus.y    = '0;
      rst_n    = 1'b0;
      for (int i = 0; i < FB_SIZE; i++) fb[i] = 8'($urandom);

      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] directed queries");
      fill(0, 0, 8'h0f);
      run_request(0, 0, 0, 0, "q00");

      fill(31, 23, 8'($urandom));
      run_request(31, 23, 0, 0, "q31_23");

      fill(5, 5, 8'haa);
      fb[64100 + 647] = 8'h55;
      run_request(5, 5, 0, 0, "q05_05");

      run_request(7, 24, 0, 0, "oor24");
      run_request(3, 31, 0, 0, "oor31");

      $display("[TB] randomized queries");
      for (int k = 0; k < 4; k++) begin
         rx  = $urandom_range(0, 31);
         ry  = $urandom_range(0, 23);
         col = 8'($urandom);
         fill(rx, ry, col);
         if ($urandom_range(0, 1) == 1) begin
            fb[pix_addr(rx, ry, $urandom_range(0, 19), $urandom_range(0, 19))] =
               col ^ 8'($urandom_range(1, 255));
         end
         run_request(rx, ry, 0, 0, "rand");
      end

`ifdef READ_SPIXEL_FAST_EN
      run_request(2, 3, 0, 0, "fast_q2_3");
`else
      $display("[TB] ignored request and mid-scan reset");
      fill(10, 10, 8'h3c);
      run_request(10, 10, 100, 200, "abort");
      run_request(10, 10, 0, 0, "after_abort");
      run_request(2, 3, 0, 0, "q2_3");
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
